// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out frame receiver.
// Frames WIDTH-bit words from a sync pulse under a per-bit strobe and presents
// each completed word on a held parallel output with a valid/ready handshake.
// Optional feature: define SIPO_PARITY_EN to add an even-parity bit after each
// frame and the perr output.
module sipo_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             sync,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    input  logic             pready,
    output logic             busy,
`ifdef SIPO_PARITY_EN
    output logic             perr,
`endif
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] pout_q;
    logic             pvalid_q;
    logic             busy_q;
    logic             ovf_q;
    logic             done;
    logic [WIDTH-1:0] word;
`ifdef SIPO_PARITY_EN
    logic             perr_q;
    logic             par_bad;
`endif

    // Shift register next value with the incoming bit at the requested end.
    always_comb begin
        if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], sin};
        end else begin
            sr_d = {sin, sr_q[WIDTH-1:1]};
        end
    end

    // Frame completion decode; a sync always wins over completion.
    always_comb begin
        done = 1'b0;
        word = sr_d;
`ifdef SIPO_PARITY_EN
        par_bad = 1'b0;
`endif
        if (!sync && bit_en) begin
            case (state_q)
`ifdef SIPO_PARITY_EN
                StPar: begin
                    done    = 1'b1;
                    word    = sr_q;
                    par_bad = ^{sr_q, sin};
                end
`else
                StShift: done = (cnt_q == LastCnt);
`endif
                default: done = 1'b0;
            endcase
        end
    end

    // Frame FSM, shift register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            ovf_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q <= done & par_bad;
`endif
            if (pvalid_q && pready) begin
                pvalid_q <= 1'b0;
            end

            if (sync) begin
                // Abort any frame in flight; a same-cycle strobe is data bit 0.
                state_q <= StShift;
                busy_q  <= 1'b1;
                if (bit_en) begin
                    sr_q  <= sr_d;
                    cnt_q <= CntW'(1);
                end else begin
                    cnt_q <= '0;
                end
            end else begin
                case (state_q)
                    StShift: begin
                        if (bit_en) begin
                            sr_q <= sr_d;
                            if (cnt_q == LastCnt) begin
`ifdef SIPO_PARITY_EN
                                state_q <= StPar;
`else
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
`endif
                            end else begin
                                cnt_q <= cnt_q + CntW'(1);
                            end
                        end
                    end
                    StPar: begin
                        if (bit_en) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end

            // Load on completion when the output slot is free or being drained.
            if (done) begin
                if (!pvalid_q || pready) begin
                    pout_q   <= word;
                    pvalid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign pout   = pout_q;
    assign pvalid = pvalid_q;
    assign busy   = busy_q;
    assign ovf    = ovf_q;
`ifdef SIPO_PARITY_EN
    assign perr   = perr_q;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: two instances (MSB-first and LSB-first) share one bit
// stream and are compared each cycle against a bit-queue reference model.
module tb_sipo_rx;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n, sin, bit_en, sync, pready;
    logic [W-1:0] pout_m, pout_l;
    logic         pvalid_m, pvalid_l, busy_m, busy_l, ovf_m, ovf_l;
`ifdef SIPO_PARITY_EN
    logic         perr_m, perr_l;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit           m_active;
    bit           m_bits[$];
    logic [W-1:0] m_pout_m, m_pout_l;
    bit           m_pvalid, m_busy, m_ovf, m_perr;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin),
        .bit_en (bit_en),
        .sync   (sync),
        .pout   (pout_m),
        .pvalid (pvalid_m),
        .pready (pready),
        .busy   (busy_m),
`ifdef SIPO_PARITY_EN
        .perr   (perr_m),
`endif
        .ovf    (ovf_m)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin),
        .bit_en (bit_en),
        .sync   (sync),
        .pout   (pout_l),
        .pvalid (pvalid_l),
        .pready (pready),
        .busy   (busy_l),
`ifdef SIPO_PARITY_EN
        .perr   (perr_l),
`endif
        .ovf    (ovf_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model one clock edge from the current inputs.
    task automatic model_step();
        bit           done;
        bit           accept;
        int           ones;
        logic [W-1:0] wm, wl;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_bits.delete();
            m_pout_m = '0;
            m_pout_l = '0;
            m_pvalid = 1'b0;
            m_busy   = 1'b0;
            return;
        end
        done   = 1'b0;
        accept = m_pvalid && pready;
        if (sync) begin
            m_active = 1'b1;
            m_bits.delete();
            if (bit_en) m_bits.push_back(sin);
        end else if (m_active && bit_en) begin
            m_bits.push_back(sin);
            if (m_bits.size() == NB) done = 1'b1;
        end
        if (accept) m_pvalid = 1'b0;
        if (done) begin
            wm   = '0;
            wl   = '0;
            ones = 0;
            for (int i = 0; i < NB; i++) begin
                if (m_bits[i]) begin
                    ones++;
                    if (i < W) begin
                        wm = wm | (W'(1) << (W - 1 - i));
                        wl = wl | (W'(1) << i);
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            m_perr = (ones % 2) == 1;
`endif
            if (!accept && m_pvalid) begin
                m_ovf = 1'b1;
            end else begin
                m_pout_m = wm;
                m_pout_l = wl;
                m_pvalid = 1'b1;
            end
            m_active = 1'b0;
            m_bits.delete();
        end
        m_busy = m_active;
    endtask

    task automatic compare_all();
        check("pout_msb", 32'(pout_m), 32'(m_pout_m));
        check("pout_lsb", 32'(pout_l), 32'(m_pout_l));
        check("pvalid_msb", 32'(pvalid_m), 32'(m_pvalid));
        check("pvalid_lsb", 32'(pvalid_l), 32'(m_pvalid));
        check("busy", 32'(busy_m), 32'(m_busy));
        check("ovf", 32'(ovf_m), 32'(m_ovf));
`ifdef SIPO_PARITY_EN
        check("perr", 32'(perr_m), 32'(m_perr));
`endif
    endtask

    // One cycle: compare at negedge, drive inputs, advance model at posedge.
    task automatic cyc(input logic s, input logic be, input logic d, input logic rdy,
                       input logic rn);
        @(negedge clk);
        compare_all();
        rst_n  = rn;
        sync   = s;
        bit_en = be;
        sin    = d;
        pready = rdy;
        @(posedge clk);
        model_step();
    endtask

    // Send one frame MSB of w first, sync on the first bit, gap idle cycles between bits.
    task automatic send(input logic [W-1:0] w, input int gap, input logic rdy,
                        input logic bad_par);
        logic b;
        for (int i = 0; i < NB; i++) begin
            b = (i < W) ? w[W-1-i] : (^w ^ bad_par);
            cyc(i == 0, 1'b1, b, rdy, 1'b1);
            if (i < NB - 1) begin
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b1);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sync   = 1'b0;
        bit_en = 1'b0;
        sin    = 1'b0;
        pready = 1'b0;
        @(posedge clk);
        model_step();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_pout", 32'(pout_m), 32'h0);
        check("rst_pvalid", 32'(pvalid_m), 32'h0);
        check("rst_busy", 32'(busy_m), 32'h0);

        // 1,0,1,1 back to back: B MSB-first, D LSB-first
        send(4'hB, 0, 1'b0, 1'b0);
        #1;
        check("frame_b_msb", 32'(pout_m), 32'hB);
        check("frame_b_lsb", 32'(pout_l), 32'hD);
        check("frame_b_valid", 32'(pvalid_m), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Same bits with 3-cycle strobe gaps
        send(4'hB, 3, 1'b1, 1'b0);
        #1;
        check("gap_lsb", 32'(pout_l), 32'hD);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stalled consumer: A held, 5 dropped with ovf
        send(4'hA, 0, 1'b0, 1'b0);
        send(4'h5, 0, 1'b0, 1'b0);
        #1;
        check("ovf_pulse", 32'(ovf_m), 32'h1);
        check("ovf_hold", 32'(pout_m), 32'hA);
        check("ovf_valid", 32'(pvalid_m), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back 3 then C with pready held high
        send(4'h3, 0, 1'b1, 1'b0);
        send(4'hC, 0, 1'b1, 1'b0);
        #1;
        check("b2b_pout", 32'(pout_m), 32'hC);

        // Abort after 2 bits, restart with same-cycle data bit
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send(4'h9, 0, 1'b1, 1'b0);
        #1;
        check("abort_pout", 32'(pout_m), 32'h9);
        check("abort_ovf", 32'(ovf_m), 32'h0);

        // Reset mid-frame
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("mid_rst_pout", 32'(pout_m), 32'h0);
        check("mid_rst_busy", 32'(busy_m), 32'h0);
        check("mid_rst_valid", 32'(pvalid_m), 32'h0);
        send(4'h6, 0, 1'b1, 1'b1);
        #1;
        check("post_rst_pout", 32'(pout_m), 32'h6);
`ifdef SIPO_PARITY_EN
        check("perr_pulse", 32'(perr_m), 32'h1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6, 1'($urandom),
                1'($urandom), $urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
